fetch_buffer: RTL

Instruction queue between the fetch stage and decode. Captures each (pc, instr) pair fetch produces and presents them in order to decode over a valid/ready handshake. Absorbs decode stalls without losing fetched words. Discards all queued entries in one cycle on a branch flush.

---
 rtl/fetch_buffer.sv | 82 ++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// In-order fetch->decode instruction queue; first-word fall-through, 1-cycle push-to-head latency.
// Backpressure: in_ready low when full, under flush or in reset; flush empties the queue in one cycle.
module fetch_buffer #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_pc,
   input  logic [XLEN-1:0]          in_instr,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_pc,
   output logic [XLEN-1:0]          out_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc_mem_q    [DEPTH];
   logic [XLEN-1:0] instr_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic full, empty, push, pop;

   assign full      = (count_q == CW'(DEPTH));
   assign empty     = (count_q == '0);
   assign in_ready  = rst && !flush && !full;
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready && !flush;

   // Empty head reads a NOP so decode never sees stale array contents.
   assign out_pc    = empty ? '0        : pc_mem_q[rd_ptr_q];
   assign out_instr = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Array is data-only: no reset, written solely on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= in_pc;
         instr_mem_q[wr_ptr_q] <= in_instr;
      end
   end

endmodule
